// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART PHY: circular FIFO, sticky overflow and idle-timeout flag.
// Define UART_RX_FIFO_STATS_EN to add the saturating dropped-byte counter drop_cnt_o.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IDLE_TICKS = 160
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tick_i,
  input  logic                  rx_vd_i,
  input  logic [7:0]            rx_data_i,
  output logic                  m_valid_o,
  output logic [7:0]            m_data_o,
  input  logic                  m_ready_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  overflow_o,
  input  logic                  ovf_clr_i,
  output logic                  idle_o
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [15:0]           drop_cnt_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [15:0] IDLE_LIM = 16'(IDLE_TICKS);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic [15:0]           idle_cnt;
  logic                  idle_q, ovf_q;
  logic                  rd, wr, drop;

  assign m_valid_o  = (count != '0);
  assign full_o     = (count == DEPTH_CNT);
  assign m_data_o   = mem[rptr];
  assign count_o    = count;
  assign overflow_o = ovf_q;
  assign idle_o     = idle_q;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign rd   = m_valid_o & m_ready_i;
  assign wr   = rx_vd_i & (~full_o | rd);
  assign drop = rx_vd_i & full_o & ~rd;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (wr && !rd)      count_nxt = count + 1'b1;
    else if (rd && !wr) count_nxt = count - 1'b1;
  end

  // NOTE: storage has no reset; count_o gates validity, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr] <= rx_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count_nxt;
      if (drop)           ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;
    end
  end

  // Idle timer restarts on each accepted byte and stops counting once the flag is up.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
      idle_q   <= 1'b0;
    end else if (wr || count_nxt == '0) begin
      idle_cnt <= '0;
      idle_q   <= 1'b0;
    end else begin
      if (idle_cnt == IDLE_LIM) idle_q <= 1'b1;
      if (tick_i && count != '0 && !idle_q && idle_cnt != IDLE_LIM)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] drop_cnt;
  assign drop_cnt_o = drop_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 drop_cnt <= '0;
    else if (drop && ovf_clr_i) drop_cnt <= 16'd1;
    else if (ovf_clr_i)        drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
  end
`else
  // Statistics counter not built.
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner sequences and random traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int IDLE = 160;
  localparam int DEPTH = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       tick_i = 1'b0, rx_vd_i = 1'b0, m_ready_i = 1'b0, ovf_clr_i = 1'b0;
  logic [7:0] rx_data_i = '0;
  logic       m_valid_o, full_o, overflow_o, idle_o;
  logic [7:0] m_data_o;
  logic [4:0] count_o;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] drop_cnt_o;
`endif

  uart_rx_fifo #(.DEPTH_LOG2(4), .IDLE_TICKS(IDLE)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .rx_vd_i(rx_vd_i), .rx_data_i(rx_data_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i), .count_o(count_o),
    .full_o(full_o), .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i), .idle_o(idle_o)
`ifdef UART_RX_FIFO_STATS_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  byte unsigned q[$];
  bit  m_ovf, m_idle;
  int  m_ticks, m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_idle = 0; m_ticks = 0; m_drop = 0;
  endtask

  task automatic model_edge(input bit vd, input byte unsigned d, input bit rdy, input bit tk, input bit clr);
    int sz = q.size();
    bit rd = (sz != 0) && rdy;
    bit wr = vd && ((sz != DEPTH) || rd);
    bit drp = vd && (sz == DEPTH) && !rd;
    bit was_idle = m_idle;
    int ticks = m_ticks;
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(d);
    if (drp) m_ovf = 1; else if (clr) m_ovf = 0;
    if (drp) m_drop = clr ? 1 : (m_drop == 65535 ? 65535 : m_drop + 1);
    else if (clr) m_drop = 0;
    if (wr || q.size() == 0) begin
      m_idle = 0; m_ticks = 0;
    end else begin
      if (ticks >= IDLE) m_idle = 1;
      if (tk && sz != 0 && !was_idle && ticks < IDLE) m_ticks = ticks + 1;
    end
  endtask

  task automatic compare_model();
    check("count", count_o, q.size());
    check("valid", m_valid_o, q.size() != 0);
    if (q.size() != 0) check("data", m_data_o, q[0]);
    check("full", full_o, q.size() == DEPTH);
    check("overflow", overflow_o, m_ovf);
    check("idle", idle_o, m_idle);
`ifdef UART_RX_FIFO_STATS_EN
    check("drop_cnt", drop_cnt_o, m_drop);
`endif
  endtask

  // Called 1 time unit after a rising edge; drives inputs, clocks once, then checks.
  task automatic step(input bit vd, input byte unsigned d, input bit rdy, input bit tk, input bit clr);
    rx_vd_i = vd; rx_data_i = d; m_ready_i = rdy; tick_i = tk; ovf_clr_i = clr;
    @(posedge clk_i);
    model_edge(vd, d, rdy, tk, clr);
    #1;
    rx_vd_i = 0; m_ready_i = 0; tick_i = 0; ovf_clr_i = 0;
    compare_model();
  endtask

  task automatic do_reset();
    rst_i = 1;
    @(posedge clk_i); @(posedge clk_i);
    #1 rst_i = 0;
    model_reset();
    compare_model();
  endtask

  typedef struct {
    logic       vd;
    logic [7:0] d;
    logic       rdy;
    logic [4:0] cnt;
    logic       vld;
    logic [7:0] dat;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte unsigned got[$];
    int t160, rise, nt;

    vecs[0] = '{1'b1, 8'h55, 1'b0, 5'd1, 1'b1, 8'h55};
    vecs[1] = '{1'b1, 8'hA3, 1'b0, 5'd2, 1'b1, 8'h55};
    vecs[2] = '{1'b1, 8'h0F, 1'b0, 5'd3, 1'b1, 8'h55};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'hA3};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h0F};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00};

    #2;
    do_reset();
    check("reset_count", count_o, 0);
    check("reset_valid", m_valid_o, 0);

    // Directed in-order write/read
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].vd, vecs[i].d, vecs[i].rdy, 0, 0);
      check("vec_count", count_o, vecs[i].cnt);
      check("vec_valid", m_valid_o, vecs[i].vld);
      if (vecs[i].vld) check("vec_data", m_data_o, vecs[i].dat);
    end

    // Fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) step(1, byte'(i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    check("ovf_full", full_o, 1);
    check("ovf_set", overflow_o, 1);
`ifdef UART_RX_FIFO_STATS_EN
    check("drop_cnt_one", drop_cnt_o, 1);
`endif
    for (int i = 0; i < 16; i++) begin
      check("drain_data", m_data_o, i);
      step(0, 0, 1, 0, 0);
    end
    check("drain_empty", m_valid_o, 0);
    step(0, 0, 0, 0, 1);
    check("ovf_clr", overflow_o, 0);
`ifdef UART_RX_FIFO_STATS_EN
    check("drop_cnt_clr", drop_cnt_o, 0);
`endif

    // Full with simultaneous read and write
    for (int i = 0; i < 16; i++) step(1, byte'(8'h10 + i), 0, 0, 0);
    step(1, 8'h77, 1, 0, 0);
    check("fullrw_ovf", overflow_o, 0);
    check("fullrw_count", count_o, 16);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("fullrw_last", m_data_o, 8'h77);
      step(0, 0, 1, 0, 0);
    end

    // Streaming through pointer wrap
    for (int i = 0; i < 21; i++) begin
      if (m_valid_o) got.push_back(m_data_o);
      step(i < 20, byte'(8'h80 + i), 1, 0, 0);
      check("wrap_count_le1", count_o <= 1, 1);
    end
    check("wrap_len", got.size(), 20);
    for (int i = 0; i < got.size(); i++) check("wrap_data", got[i], 8'h80 + i);

    // Idle timeout with a tick every 4 clocks
    step(1, 8'h42, 0, 0, 0);
    t160 = -1; rise = -1; nt = 0;
    for (int i = 0; i < 800 && rise < 0; i++) begin
      step(0, 0, 0, (i % 4) == 0, 0);
      if ((i % 4) == 0) begin
        nt++;
        if (nt == IDLE) t160 = i;
      end
      if (idle_o) rise = i;
    end
    check("idle_latency", rise - t160, 1);
    step(1, 8'h43, 0, 0, 0);
    check("idle_clr_write", idle_o, 0);
    rise = -1;
    for (int i = 0; i < 200 && rise < 0; i++) begin
      step(0, 0, 0, 1, 0);
      if (idle_o) rise = i;
    end
    check("idle_again", idle_o, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("idle_clr_drain", idle_o, 0);
    check("idle_drain_count", count_o, 0);

    // Asynchronous reset mid-fill
    for (int i = 0; i < 5; i++) step(1, byte'(8'hA0 + i), 0, 0, 0);
    check("pre_rst_count", count_o, 5);
    #2 rst_i = 1;
    #1;
    check("async_count", count_o, 0);
    check("async_valid", m_valid_o, 0);
    check("async_full", full_o, 0);
    check("async_ovf", overflow_o, 0);
    check("async_idle", idle_o, 0);
    @(posedge clk_i);
    #1 rst_i = 0;
    model_reset();
    step(1, 8'hC3, 0, 0, 0);
    check("post_rst_data", m_data_o, 8'hC3);
    check("post_rst_count", count_o, 1);

    // Random traffic with alternating fill/drain bias
    for (int i = 0; i < 2000; i++) begin
      bit rdy = ((i / 100) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      step($urandom_range(1) == 1, byte'($urandom), rdy, $urandom_range(1) == 1,
           $urandom_range(15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
